// File: rtl/cacc_pingpong_regfile.sv
// CACC register front-end: single-copy status/pointer registers, ping-pong
// producer/consumer pointers, per-group op_en and saturation-count capture.
module cacc_pingpong_regfile #(
  parameter int RESP_PIPE = 1  // response latency; only 1 is implemented
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        req_pvld,
  output logic        req_prdy,
  input  logic [11:0] req_offset,
  input  logic [31:0] req_wdat,
  input  logic        req_write,
  input  logic        req_nposted,
  output logic        resp_valid,
  output logic [33:0] resp_pd,
  output logic [11:0] reg_offset,
  output logic [31:0] reg_wr_data,
  output logic        reg_wr_en_d0,
  output logic        reg_wr_en_d1,
  input  logic [31:0] reg_rd_data_d0,
  input  logic [31:0] reg_rd_data_d1,
  input  logic        op_en_trigger_d0,
  input  logic        op_en_trigger_d1,
  output logic        op_en_d0,
  output logic        op_en_d1,
  output logic [31:0] sat_count_d0,
  output logic [31:0] sat_count_d1,
  input  logic        dp2reg_done,
  input  logic [31:0] dp2reg_sat_count,
  output logic        reg2dp_op_en,
  output logic        reg2dp_consumer
);

  localparam logic [11:0] STATUS_OFF  = 12'h000;
  localparam logic [11:0] POINTER_OFF = 12'h004;
  localparam logic [11:0] DUAL_LO     = 12'h008;
  localparam logic [11:0] DUAL_HI     = 12'h034;

  typedef enum logic [1:0] {
    GRP_IDLE    = 2'd0,
    GRP_RUNNING = 2'd1,
    GRP_PENDING = 2'd2
  } grp_status_e;

  logic        producer;
  logic        consumer;
  logic        is_dual;
  logic        wr_req;
  logic        resp_needed;
  grp_status_e status0;
  grp_status_e status1;
  logic        consumer_nxt;
  logic        op_en_d0_nxt;
  logic        op_en_d1_nxt;
  logic [31:0] rdata;

  function automatic grp_status_e grp_status(input logic op_en, input logic is_consumer);
    if (!op_en)          return GRP_IDLE;
    else if (is_consumer) return GRP_RUNNING;
    else                 return GRP_PENDING;
  endfunction

  // The router is never back-pressured: one request per cycle is always taken.
  assign req_prdy    = 1'b1;
  assign reg_offset  = req_offset;
  assign reg_wr_data = req_wdat;

  assign is_dual     = (req_offset >= DUAL_LO) && (req_offset <= DUAL_HI);
  assign wr_req      = req_pvld & req_write;
  assign resp_needed = req_pvld & (~req_write | req_nposted);

  // A group that holds op_en is locked against writes until its layer completes.
  assign reg_wr_en_d0 = wr_req & is_dual & ~producer & ~op_en_d0;
  assign reg_wr_en_d1 = wr_req & is_dual &  producer & ~op_en_d1;

  assign status0 = grp_status(op_en_d0, ~consumer);
  assign status1 = grp_status(op_en_d1,  consumer);

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    consumer_nxt = consumer ^ dp2reg_done;
    op_en_d0_nxt = op_en_d0;
    op_en_d1_nxt = op_en_d1;
    if (op_en_trigger_d0 && reg_wr_en_d0 && req_wdat[0]) op_en_d0_nxt = 1'b1;
    if (op_en_trigger_d1 && reg_wr_en_d1 && req_wdat[0]) op_en_d1_nxt = 1'b1;
    if (dp2reg_done && !consumer) op_en_d0_nxt = 1'b0;
    if (dp2reg_done &&  consumer) op_en_d1_nxt = 1'b0;
  end

  always_comb begin
    rdata = 32'h0;
    if (req_offset == STATUS_OFF)
      rdata = {14'b0, status1, 14'b0, status0};
    else if (req_offset == POINTER_OFF)
      rdata = {15'b0, consumer, 15'b0, producer};
    else if (is_dual)
      rdata = producer ? reg_rd_data_d1 : reg_rd_data_d0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      producer     <= 1'b0;
      consumer     <= 1'b0;
      op_en_d0     <= 1'b0;
      op_en_d1     <= 1'b0;
      sat_count_d0 <= 32'h0;
      sat_count_d1 <= 32'h0;
      reg2dp_op_en <= 1'b0;
      resp_valid   <= 1'b0;
      resp_pd      <= 34'h0;
    end else begin
      if (wr_req && req_offset == POINTER_OFF) producer <= req_wdat[0];
      consumer     <= consumer_nxt;
      op_en_d0     <= op_en_d0_nxt;
      op_en_d1     <= op_en_d1_nxt;
      if (dp2reg_done && !consumer) sat_count_d0 <= dp2reg_sat_count;
      if (dp2reg_done &&  consumer) sat_count_d1 <= dp2reg_sat_count;
      reg2dp_op_en <= consumer_nxt ? op_en_d1_nxt : op_en_d0_nxt;
      resp_valid   <= resp_needed;
      if (!resp_needed)   resp_pd <= 34'h0;
      else if (req_write) resp_pd <= {1'b1, 1'b0, 32'h0};
      else                resp_pd <= {1'b0, 1'b0, rdata};
    end
  end

  assign reg2dp_consumer = consumer;

endmodule

// File: tb/tb_cacc_pingpong_regfile.sv
// Directed bench for cacc_pingpong_regfile: expected responses are queued at
// request time and compared when resp_valid appears one cycle later.
module tb_cacc_pingpong_regfile;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_pvld = 1'b0;
  logic        req_prdy;
  logic [11:0] req_offset = '0;
  logic [31:0] req_wdat = '0;
  logic        req_write = 1'b0;
  logic        req_nposted = 1'b0;
  logic        resp_valid;
  logic [33:0] resp_pd;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en_d0, reg_wr_en_d1;
  logic [31:0] reg_rd_data_d0 = 32'hD0D0_5678;
  logic [31:0] reg_rd_data_d1 = 32'hD1D1_1234;
  logic        op_en_trigger_d0, op_en_trigger_d1;
  logic        op_en_d0, op_en_d1;
  logic [31:0] sat_count_d0, sat_count_d1;
  logic        dp2reg_done = 1'b0;
  logic [31:0] dp2reg_sat_count = '0;
  logic        reg2dp_op_en, reg2dp_consumer;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  // Each group decodes its own OP_ENABLE register at offset 0x008.
  assign op_en_trigger_d0 = req_pvld & req_write & (req_offset == 12'h008);
  assign op_en_trigger_d1 = req_pvld & req_write & (req_offset == 12'h008);

  cacc_pingpong_regfile #(.RESP_PIPE(1)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .req_pvld(req_pvld), .req_prdy(req_prdy), .req_offset(req_offset),
    .req_wdat(req_wdat), .req_write(req_write), .req_nposted(req_nposted),
    .resp_valid(resp_valid), .resp_pd(resp_pd),
    .reg_offset(reg_offset), .reg_wr_data(reg_wr_data),
    .reg_wr_en_d0(reg_wr_en_d0), .reg_wr_en_d1(reg_wr_en_d1),
    .reg_rd_data_d0(reg_rd_data_d0), .reg_rd_data_d1(reg_rd_data_d1),
    .op_en_trigger_d0(op_en_trigger_d0), .op_en_trigger_d1(op_en_trigger_d1),
    .op_en_d0(op_en_d0), .op_en_d1(op_en_d1),
    .sat_count_d0(sat_count_d0), .sat_count_d1(sat_count_d1),
    .dp2reg_done(dp2reg_done), .dp2reg_sat_count(dp2reg_sat_count),
    .reg2dp_op_en(reg2dp_op_en), .reg2dp_consumer(reg2dp_consumer)
  );

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the response slot one cycle after acceptance against the queue.
  task automatic check_resp(input string tag);
    if (exp_q.size() > 0) begin
      check({tag, " resp_valid"}, 34'(resp_valid), 34'd1);
      check({tag, " resp_pd"}, resp_pd, exp_q.pop_front());
    end else begin
      check({tag, " no resp"}, 34'(resp_valid), 34'd0);
    end
  endtask

  // Called #1 after a rising edge: drive, check the strobes, accept, check the response.
  task automatic issue(input string tag, input logic [11:0] off, input logic [31:0] wd,
                       input logic wr, input logic np, input logic [33:0] exp_pd,
                       input logic exp_wr0, input logic exp_wr1);
    req_pvld = 1'b1; req_offset = off; req_wdat = wd; req_write = wr; req_nposted = np;
    if (!wr || np) exp_q.push_back(exp_pd);
    #1;
    if (wr) begin
      check({tag, " wr_en_d0"}, 34'(reg_wr_en_d0), 34'(exp_wr0));
      check({tag, " wr_en_d1"}, 34'(reg_wr_en_d1), 34'(exp_wr1));
    end
    @(posedge clk); #1;
    req_pvld = 1'b0; req_write = 1'b0; req_nposted = 1'b0;
    check_resp(tag);
  endtask

  task automatic pulse_done(input logic [31:0] sat);
    dp2reg_done = 1'b1; dp2reg_sat_count = sat;
    @(posedge clk); #1;
    dp2reg_done = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " prdy"},     34'(req_prdy), 34'd1);
    check({tag, " resp_vld"}, 34'(resp_valid), 34'd0);
    check({tag, " resp_pd"},  resp_pd, 34'd0);
    check({tag, " op_en"},    34'({op_en_d0, op_en_d1, reg2dp_op_en}), 34'd0);
    check({tag, " consumer"}, 34'(reg2dp_consumer), 34'd0);
    check({tag, " sat0"},     34'(sat_count_d0), 34'd0);
    check({tag, " sat1"},     34'(sat_count_d1), 34'd0);
  endtask

  localparam logic [33:0] ACK = {1'b1, 1'b0, 32'h0};

  initial begin
    #12;
    check_reset_state("reset");
    check("reset wr_en", 34'({reg_wr_en_d0, reg_wr_en_d1}), 34'd0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    issue("rd status", 12'h000, 32'h0, 1'b0, 1'b0, 34'h0, 1'b0, 1'b0);
    issue("rd pointer", 12'h004, 32'h0, 1'b0, 1'b0, 34'h0, 1'b0, 1'b0);

    // Producer to group 1; dual-space traffic follows it.
    issue("wr pointer=1", 12'h004, 32'h0001_0001, 1'b1, 1'b0, 34'h0, 1'b0, 1'b0);
    issue("rd pointer p1", 12'h004, 32'h0, 1'b0, 1'b0, 34'h0_0000_0001, 1'b0, 1'b0);
    req_pvld = 1'b1; req_offset = 12'h010; req_wdat = 32'h0010_0020; req_write = 1'b1;
    #1;
    check("pass offset", 34'(reg_offset), 34'h010);
    check("pass wdata", 34'(reg_wr_data), 34'h0010_0020);
    req_pvld = 1'b0; req_write = 1'b0;
    issue("wr g1 0x010", 12'h010, 32'h0010_0020, 1'b1, 1'b0, 34'h0, 1'b0, 1'b1);
    issue("rd g1 0x010", 12'h010, 32'h0, 1'b0, 1'b0, {2'b00, 32'hD1D1_1234}, 1'b0, 1'b0);

    // Start group 0, then confirm it is locked.
    issue("wr pointer=0", 12'h004, 32'h0, 1'b1, 1'b0, 34'h0, 1'b0, 1'b0);
    issue("rd g0 0x00C", 12'h00C, 32'h0, 1'b0, 1'b0, {2'b00, 32'hD0D0_5678}, 1'b0, 1'b0);
    issue("op_enable g0", 12'h008, 32'h1, 1'b1, 1'b0, 34'h0, 1'b1, 1'b0);
    check("op_en_d0 set", 34'(op_en_d0), 34'd1);
    check("reg2dp_op_en g0", 34'(reg2dp_op_en), 34'd1);
    issue("rd status run", 12'h000, 32'h0, 1'b0, 1'b0, 34'h0_0000_0001, 1'b0, 1'b0);
    issue("wr g0 locked", 12'h00C, 32'hABCD, 1'b1, 1'b0, 34'h0, 1'b0, 1'b0);

    // Queue group 1 behind it.
    issue("wr pointer=1b", 12'h004, 32'h1, 1'b1, 1'b0, 34'h0, 1'b0, 1'b0);
    issue("op_enable g1", 12'h008, 32'h1, 1'b1, 1'b0, 34'h0, 1'b0, 1'b1);
    issue("rd status pend", 12'h000, 32'h0, 1'b0, 1'b0, 34'h0_0002_0001, 1'b0, 1'b0);

    pulse_done(32'd77);
    check("sat0 captured", 34'(sat_count_d0), 34'd77);
    check("op_en_d0 clr", 34'(op_en_d0), 34'd0);
    check("consumer=1", 34'(reg2dp_consumer), 34'd1);
    check("reg2dp_op_en held", 34'(reg2dp_op_en), 34'd1);
    issue("rd status g1", 12'h000, 32'h0, 1'b0, 1'b0, 34'h0_0001_0000, 1'b0, 1'b0);
    issue("rd pointer c1", 12'h004, 32'h0, 1'b0, 1'b0, 34'h0_0001_0001, 1'b0, 1'b0);

    // Dropped and unmapped writes.
    issue("np wr locked g1", 12'h00C, 32'h5, 1'b1, 1'b1, ACK, 1'b0, 1'b0);
    issue("np wr 0x100", 12'h100, 32'h5, 1'b1, 1'b1, ACK, 1'b0, 1'b0);
    issue("posted wr 0x100", 12'h100, 32'h5, 1'b1, 1'b0, 34'h0, 1'b0, 1'b0);
    issue("rd 0x100", 12'h100, 32'h0, 1'b0, 1'b0, 34'h0, 1'b0, 1'b0);
    issue("rd 0x038", 12'h038, 32'h0, 1'b0, 1'b0, 34'h0, 1'b0, 1'b0);

    // Group 1 finishes with nothing pending; then a done on an idle group.
    pulse_done(32'd5);
    check("sat1 captured", 34'(sat_count_d1), 34'd5);
    check("consumer=0", 34'(reg2dp_consumer), 34'd0);
    check("reg2dp_op_en drop", 34'(reg2dp_op_en), 34'd0);
    pulse_done(32'd9);
    check("idle done sat0", 34'(sat_count_d0), 34'd9);
    check("idle done consumer", 34'(reg2dp_consumer), 34'd1);
    check("idle done op_en", 34'({op_en_d0, op_en_d1}), 34'd0);
    issue("op_enable g1 b", 12'h008, 32'h1, 1'b1, 1'b0, 34'h0, 1'b0, 1'b1);
    check("op_en_d1 again", 34'(op_en_d1), 34'd1);
    check("reg2dp_op_en g1", 34'(reg2dp_op_en), 34'd1);
    issue("wr op_enable 0", 12'h008, 32'h0, 1'b1, 1'b0, 34'h0, 1'b0, 1'b0);
    check("op_en_d1 kept", 34'(op_en_d1), 34'd1);

    // Reset while a read response is on the bus.
    req_pvld = 1'b1; req_offset = 12'h000; req_write = 1'b0;
    @(posedge clk); #1;
    req_pvld = 1'b0;
    check("pre-reset resp", 34'(resp_valid), 34'd1);
    rstn = 1'b0;
    #1;
    check_reset_state("mid reset");
    exp_q.delete();
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post reset no resp", 34'(resp_valid), 34'd0);
    end
    issue("rd pointer post", 12'h004, 32'h0, 1'b0, 1'b0, 34'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
